// File: rtl/adc_framer_pkg.sv
// Shared types and constants for the ADC sample framer.
package adc_framer_pkg;

  localparam int SAMPLE_W = 12;
  localparam int BYTE_W   = 8;

  localparam logic [BYTE_W-1:0] HDR0_BYTE = 8'hA5;
  localparam logic [BYTE_W-1:0] HDR1_BYTE = 8'h5A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_SEQ,
    S_PAYLOAD,
    S_CSUM
  } frame_state_t;

  // Returns {byte0, byte1, byte2} for an (older, newer) sample pair.
  function automatic logic [3*BYTE_W-1:0] pack_pair(input logic [SAMPLE_W-1:0] a,
                                                    input logic [SAMPLE_W-1:0] b);
    return {a[11:4], a[3:0], b[11:8], b[7:0]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous show-ahead FIFO; pushes while full are ignored even if a pop occurs.
module sample_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 12
) (
  input  logic                     I_clk,
  input  logic                     I_rst_n,
  input  logic                     I_push,
  input  logic [WIDTH-1:0]         I_wdata,
  input  logic                     I_pop,
  output logic [WIDTH-1:0]         O_rdata,
  output logic                     O_full,
  output logic                     O_empty,
  output logic [$clog2(DEPTH):0]   O_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign O_full  = (count == (AW+1)'(DEPTH));
  assign O_empty = (count == '0);
  assign O_count = count;
  assign O_rdata = mem[rd_ptr];
  assign do_push = I_push & ~O_full;
  assign do_pop  = I_pop & ~O_empty;

  always_ff @(posedge I_clk) begin
    if (do_push) mem[wr_ptr] <= I_wdata;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/adc_sample_framer.sv
// Buffers 12-bit ADC samples and emits them as checksummed byte frames.
//   state   | meaning
//   IDLE    | waiting for a full frame's worth of samples
//   HDR0    | presenting 0xA5
//   HDR1    | presenting 0x5A, pops first sample of pair 0 on transfer
//   SEQ     | presenting sequence number, pops second sample of pair 0
//   PAYLOAD | presenting packed pair bytes, prefetching the next pair
//   CSUM    | presenting checksum, sequence number advances on transfer
module adc_sample_framer
  import adc_framer_pkg::*;
#(
  parameter int PAIRS_PER_FRAME = 8,
  parameter int FIFO_DEPTH      = 32
) (
  input  logic                I_clk,
  input  logic                I_rst_n,
  input  logic                I_data_valid,
  input  logic [SAMPLE_W-1:0] I_data,
  input  logic                I_byte_ready,
  output logic                O_byte_valid,
  output logic [BYTE_W-1:0]   O_byte,
  output logic                O_busy,
  output logic                O_overflow,
  output logic [15:0]         O_drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = (PAIRS_PER_FRAME > 1) ? $clog2(PAIRS_PER_FRAME) : 1;

  frame_state_t          state, next_state;
  logic [BYTE_W-1:0]     seq, csum, byte_out;
  logic [3*BYTE_W-1:0]   pair_bytes;
  logic [SAMPLE_W-1:0]   next_a, fifo_rdata;
  logic [1:0]            byte_idx;
  logic [PW-1:0]         pair_idx;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_full, fifo_empty, pop, xfer, last_pair, drop;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(SAMPLE_W)) u_fifo (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_push  (I_data_valid),
    .I_wdata (I_data),
    .I_pop   (pop),
    .O_rdata (fifo_rdata),
    .O_full  (fifo_full),
    .O_empty (fifo_empty),
    .O_count (fifo_count)
  );

  assign O_byte_valid = (state != S_IDLE);
  assign O_busy       = (state != S_IDLE);
  assign O_byte       = byte_out;
  assign xfer         = O_byte_valid & I_byte_ready;
  assign last_pair    = (pair_idx == PW'(PAIRS_PER_FRAME - 1));
  assign drop         = I_data_valid & fifo_full;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    byte_out   = '0;
    pop        = 1'b0;
    case (state)
      S_IDLE:    if (fifo_count >= CW'(2 * PAIRS_PER_FRAME)) next_state = S_HDR0;
      S_HDR0: begin
        byte_out = HDR0_BYTE;
        if (xfer) next_state = S_HDR1;
      end
      S_HDR1: begin
        byte_out = HDR1_BYTE;
        if (xfer) begin
          next_state = S_SEQ;
          pop        = ~fifo_empty;
        end
      end
      S_SEQ: begin
        byte_out = seq;
        if (xfer) begin
          next_state = S_PAYLOAD;
          pop        = ~fifo_empty;
        end
      end
      S_PAYLOAD: begin
        case (byte_idx)
          2'd0:    byte_out = pair_bytes[23:16];
          2'd1:    byte_out = pair_bytes[15:8];
          default: byte_out = pair_bytes[7:0];
        endcase
        if (xfer) begin
          if (byte_idx == 2'd2 && last_pair) next_state = S_CSUM;
          // Next pair's A is popped on byte0, B on byte2.
          if (!last_pair && byte_idx != 2'd1) pop = ~fifo_empty;
        end
      end
      S_CSUM: begin
        byte_out = csum;
        if (xfer) next_state = S_IDLE;
      end
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      seq          <= '0;
      csum         <= '0;
      pair_bytes   <= '0;
      next_a       <= '0;
      byte_idx     <= '0;
      pair_idx     <= '0;
      O_overflow   <= 1'b0;
      O_drop_count <= '0;
    end else begin
      if (drop) begin
        O_overflow <= 1'b1;
        if (O_drop_count != 16'hFFFF) O_drop_count <= O_drop_count + 16'd1;
      end
      if (state == S_IDLE) begin
        csum     <= '0;
        byte_idx <= '0;
        pair_idx <= '0;
      end
      if (xfer) begin
        case (state)
          S_HDR1: next_a <= fifo_rdata;
          S_SEQ: begin
            pair_bytes <= pack_pair(next_a, fifo_rdata);
            csum       <= csum + seq;
          end
          S_PAYLOAD: begin
            csum <= csum + byte_out;
            if (byte_idx == 2'd2) begin
              byte_idx <= '0;
              pair_idx <= pair_idx + 1'b1;
              if (!last_pair) pair_bytes <= pack_pair(next_a, fifo_rdata);
            end else begin
              byte_idx <= byte_idx + 2'd1;
              if (byte_idx == 2'd0) next_a <= fifo_rdata;
            end
          end
          S_CSUM:  seq <= seq + 8'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_framer.sv
// Directed self-checking bench for adc_sample_framer.
module tb_adc_sample_framer;
  import adc_framer_pkg::*;

  localparam int FRAME_LEN = 28;

  logic        I_clk = 1'b0;
  logic        I_rst_n;
  logic        I_data_valid;
  logic [11:0] I_data;
  logic        I_byte_ready;
  logic        O_byte_valid;
  logic [7:0]  O_byte;
  logic        O_busy;
  logic        O_overflow;
  logic [15:0] O_drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  frame_buf [FRAME_LEN];
  logic [7:0]  exp_buf   [FRAME_LEN];
  logic [7:0]  ref_buf   [FRAME_LEN];
  logic [11:0] smp       [16];

  adc_sample_framer dut (
    .I_clk        (I_clk),
    .I_rst_n      (I_rst_n),
    .I_data_valid (I_data_valid),
    .I_data       (I_data),
    .I_byte_ready (I_byte_ready),
    .O_byte_valid (O_byte_valid),
    .O_byte       (O_byte),
    .O_busy       (O_busy),
    .O_overflow   (O_overflow),
    .O_drop_count (O_drop_count)
  );

  always #5 I_clk = ~I_clk;

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_samples();
    for (int i = 0; i < 16; i++) begin
      I_data_valid = 1'b1;
      I_data       = smp[i];
      tick();
    end
    I_data_valid = 1'b0;
  endtask

  // Collects frame bytes from index start; optional random ready with hold checks.
  task automatic collect_frame(input bit rand_rdy, input int start);
    int         n = start;
    int         cyc = 0;
    bit         stalled = 0;
    logic [7:0] last = '0;
    while (n < FRAME_LEN && cyc < 3000) begin
      I_byte_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        check("stall_hold_byte", O_byte, last);
        check("stall_hold_valid", O_byte_valid, 1);
      end
      stalled = 0;
      if (O_byte_valid && I_byte_ready) begin
        frame_buf[n] = O_byte;
        n++;
      end else if (O_byte_valid) begin
        stalled = 1;
        last    = O_byte;
      end
      tick();
      cyc++;
    end
    check("frame_complete_in_budget", n, FRAME_LEN);
    I_byte_ready = 1'b1;
  endtask

  task automatic check_frame(input logic [7:0] seq);
    int s;
    exp_buf[0] = 8'hA5;
    exp_buf[1] = 8'h5A;
    exp_buf[2] = seq;
    for (int k = 0; k < 8; k++) begin
      exp_buf[3 + 3*k] = 8'((smp[2*k] >> 4) & 12'hFF);
      exp_buf[4 + 3*k] = 8'(((smp[2*k] & 12'hF) << 4) | (smp[2*k+1] >> 8));
      exp_buf[5 + 3*k] = 8'(smp[2*k+1] & 12'hFF);
    end
    s = 0;
    for (int i = 2; i < FRAME_LEN - 1; i++) s += int'(exp_buf[i]);
    exp_buf[FRAME_LEN-1] = 8'(s % 256);
    for (int i = 0; i < FRAME_LEN; i++)
      check($sformatf("frame_seq%0d_byte%0d", seq, i), frame_buf[i], exp_buf[i]);
  endtask

  initial begin
    int k;
    I_rst_n = 1'b0; I_data_valid = 1'b0; I_data = '0; I_byte_ready = 1'b0;
    tick(); tick();
    check("rst_byte_valid", O_byte_valid, 0);
    check("rst_byte", O_byte, 0);
    check("rst_busy", O_busy, 0);
    check("rst_overflow", O_overflow, 0);
    check("rst_drop_count", O_drop_count, 0);
    I_rst_n = 1'b1;
    tick();

    // Single frame, ready held high
    I_byte_ready = 1'b1;
    for (int i = 0; i < 16; i++) smp[i] = 12'(i);
    push_samples();
    check("latency_idle_at_threshold", O_byte_valid, 0);
    tick();
    check("latency_hdr0_valid", O_byte_valid, 1);
    check("latency_hdr0_byte", O_byte, 8'hA5);
    check("busy_in_frame", O_busy, 1);
    collect_frame(0, 0);
    check("busy_fall_after_csum", O_busy, 0);
    check_frame(8'h00);
    check("t1_byte4", frame_buf[4], 8'h00);
    check("t1_byte5", frame_buf[5], 8'h01);
    check("t1_byte7", frame_buf[7], 8'h20);
    check("t1_byte8", frame_buf[8], 8'h03);
    check("t1_csum", frame_buf[27], 8'hC0);
    for (int i = 0; i < FRAME_LEN; i++) ref_buf[i] = frame_buf[i];

    // Backpressure with same samples
    push_samples();
    collect_frame(1, 0);
    check_frame(8'h01);
    for (int i = 3; i < FRAME_LEN - 1; i++)
      check($sformatf("bp_payload_match%0d", i), frame_buf[i], ref_buf[i]);
    check("bp_csum", frame_buf[27], 8'hC1);

    // Overflow: 40 samples, ready low
    I_byte_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      I_data_valid = 1'b1;
      I_data       = 12'(i);
      tick();
    end
    I_data_valid = 1'b0;
    check("ovf_flag", O_overflow, 1);
    check("ovf_drop_count", O_drop_count, 8);
    check("ovf_fifo_count", 32'(dut.u_fifo.O_count), 32);
    check("ovf_stalled_hdr0", O_byte, 8'hA5);

    // Full FIFO, push together with the first pop-free HDR0 transfer then pop
    I_byte_ready = 1'b1;
    I_data_valid = 1'b1;
    I_data       = 12'hFFF;
    tick();
    I_data_valid = 1'b1;
    I_data       = 12'hFFE;
    check("fullpop_state_hdr1", O_byte, 8'h5A);
    tick();
    I_data_valid = 1'b0;
    check("fullpop_drop_count", O_drop_count, 10);
    check("fullpop_fifo_count", 32'(dut.u_fifo.O_count), 31);
    frame_buf[0] = 8'hA5;
    frame_buf[1] = 8'h5A;
    collect_frame(0, 2);
    for (int i = 0; i < 16; i++) smp[i] = 12'(i);
    check_frame(8'h02);
    collect_frame(0, 0);
    for (int i = 0; i < 16; i++) smp[i] = 12'(16 + i);
    check_frame(8'h03);
    check("drain_fifo_empty", 32'(dut.u_fifo.O_count), 0);

    // Mid-frame reset
    for (int i = 0; i < 16; i++) smp[i] = 12'(12'h100 + 12'(i * 7));
    push_samples();
    for (k = 0; k < 100 && dut.state != S_PAYLOAD; k++) tick();
    check("reach_payload", 32'(dut.state), 32'(S_PAYLOAD));
    tick(); tick();
    I_rst_n = 1'b0;
    #1;
    check("mrst_byte_valid", O_byte_valid, 0);
    check("mrst_busy", O_busy, 0);
    check("mrst_overflow", O_overflow, 0);
    check("mrst_drop_count", O_drop_count, 0);
    check("mrst_fifo_count", 32'(dut.u_fifo.O_count), 0);
    tick();
    I_rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) smp[i] = 12'(12'h800 + 12'(i * 13));
    push_samples();
    collect_frame(0, 0);
    check_frame(8'h00);

    // SEQ wrap over 257 frames
    I_rst_n = 1'b0;
    tick();
    I_rst_n = 1'b1;
    tick();
    for (int f = 0; f < 257; f++) begin
      for (int i = 0; i < 16; i++) smp[i] = 12'((f * 37 + i * 291) & 12'hFFF);
      push_samples();
      collect_frame(0, 0);
      check_frame(8'(f % 256));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
